board_io_pio: RTL and testbench

Parametrised board I/O conditioner. It is the successor to the bare inverting wires that currently feed the button/switch PIOs and drive the LEDs. It synchronises and debounces IN_WIDTH raw push-button/switch inputs and normalises their polarity. It also records press/release edges in sticky, maskable capture bits that drive a level interrupt. On the LED side it drives LED_WIDTH outputs with per-LED blink and polarity control. It sits between the board pins and the Qsys PIO exports in the top level, on the system clock.

---
 rtl/board_io_pio.sv | 138 +++++++++++++
 tb/tb_board_io_pio.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/board_io_pio.sv
// board_io_pio: board-pin conditioner sitting between KEY/SW/LED pins and the
// PIO exports. Inputs are polarity-normalised, synchronised, debounced and
// edge-captured into sticky maskable flags; LEDs get per-bit blink gating and
// output polarity handling. Everything runs on clk with a synchronous,
// active-low reset.
module board_io_pio #(
    parameter int IN_WIDTH        = 4,
    parameter int LED_WIDTH       = 8,
    parameter int IN_ACTIVE_LOW   = 1,
    parameter int LED_ACTIVE_LOW  = 1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20,
    parameter int EDGE_MODE       = 0,
    parameter int BLINK_DIV_W     = 24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IN_WIDTH-1:0]  in_raw,
    output logic [IN_WIDTH-1:0]  in_level,
    output logic [IN_WIDTH-1:0]  edge_capture,
    input  logic [IN_WIDTH-1:0]  edge_clear,
    input  logic [IN_WIDTH-1:0]  irq_mask,
    output logic                 irq,
    input  logic [LED_WIDTH-1:0] led_value,
    input  logic [LED_WIDTH-1:0] led_blink_en,
    output logic [LED_WIDTH-1:0] led_out
);

    // Inversion masks so that everything internal is active-high.
    localparam logic [IN_WIDTH-1:0]  IN_INV  = (IN_ACTIVE_LOW != 0)  ? {IN_WIDTH{1'b1}}  : {IN_WIDTH{1'b0}};
    localparam logic [LED_WIDTH-1:0] LED_INV = (LED_ACTIVE_LOW != 0) ? {LED_WIDTH{1'b1}} : {LED_WIDTH{1'b0}};
    // Terminal count: the change is accepted on the cycle the counter sits here.
    localparam logic [DB_CNT_W-1:0]  DB_MAX  = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [IN_WIDTH-1:0]    sync1_reg;
    logic [IN_WIDTH-1:0]    sync2_reg;
    logic [IN_WIDTH-1:0]    in_level_reg;
    logic [IN_WIDTH-1:0]    edge_capture_reg;
    logic [IN_WIDTH-1:0]    edge_capture_next;
    logic [IN_WIDTH-1:0]    differ;
    logic [IN_WIDTH-1:0]    accept;
    logic [IN_WIDTH-1:0]    rise;
    logic [IN_WIDTH-1:0]    fall;
    logic [IN_WIDTH-1:0]    edge_set;
    logic [DB_CNT_W-1:0]    db_cnt_reg [IN_WIDTH];

    logic [BLINK_DIV_W-1:0] blink_div_reg;
    logic                   blink_phase;
    logic [LED_WIDTH-1:0]   led_on;
    logic [LED_WIDTH-1:0]   led_out_reg;

    // Two-flop synchroniser on the polarity-normalised raw inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= in_raw ^ IN_INV;
            sync2_reg <= sync1_reg;
        end
    end

    // Per-channel debounce: count consecutive cycles the synchronised input
    // disagrees with the accepted level; any agreement restarts the count.
    generate
        for (genvar gi = 0; gi < IN_WIDTH; gi++) begin : g_db
            assign differ[gi] = sync2_reg[gi] ^ in_level_reg[gi];
            assign accept[gi] = differ[gi] && (db_cnt_reg[gi] == DB_MAX);

            // Debounce counter for this channel.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    db_cnt_reg[gi] <= '0;
                end else if (!differ[gi] || accept[gi]) begin
                    db_cnt_reg[gi] <= '0;
                end else begin
                    db_cnt_reg[gi] <= db_cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    // An accepted change always flips the level, so direction follows from
    // the level before the flip.
    assign rise = accept & ~in_level_reg;
    assign fall = accept & in_level_reg;

    // Select which level transitions raise a capture flag.
    always_comb begin
        edge_set = rise;
        if (EDGE_MODE == 1) begin
            edge_set = fall;
        end else if (EDGE_MODE == 2) begin
            edge_set = rise | fall;
        end
    end

    // Clear first, then OR in new events so a same-cycle set is never lost.
    assign edge_capture_next = (edge_capture_reg & ~edge_clear) | edge_set;

    // Accepted level and sticky edge flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            in_level_reg     <= '0;
            edge_capture_reg <= '0;
        end else begin
            in_level_reg     <= in_level_reg ^ accept;
            edge_capture_reg <= edge_capture_next;
        end
    end

    // Free-running blink divider; its MSB gives a 50% duty phase.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blink_div_reg <= '0;
        end else begin
            blink_div_reg <= blink_div_reg + 1'b1;
        end
    end

    assign blink_phase = blink_div_reg[BLINK_DIV_W-1];
    assign led_on      = led_value & (~led_blink_en | {LED_WIDTH{blink_phase}});

    // Registered LED pins with board polarity applied; reset shows all off.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_out_reg <= LED_INV;
        end else begin
            led_out_reg <= led_on ^ LED_INV;
        end
    end

    assign in_level     = in_level_reg;
    assign edge_capture = edge_capture_reg;
    assign irq          = |(edge_capture_reg & irq_mask);
    assign led_out      = led_out_reg;

endmodule

// File: tb/tb_board_io_pio.sv
// Directed bench for board_io_pio: reset values, debounce latency, bounce
// rejection, set/clear race, blink pattern and reset during debounce.
module tb_board_io_pio;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] in_raw;
    logic [1:0] in_level;
    logic [1:0] edge_capture;
    logic [1:0] edge_clear;
    logic [1:0] irq_mask;
    logic       irq;
    logic [3:0] led_value;
    logic [3:0] led_blink_en;
    logic [3:0] led_out;

    int total = 0;
    int bad   = 0;

    logic samp [40];
    int   t0;

    board_io_pio #(
        .IN_WIDTH        (2),
        .LED_WIDTH       (4),
        .IN_ACTIVE_LOW   (1),
        .LED_ACTIVE_LOW  (1),
        .DEBOUNCE_CYCLES (8),
        .DB_CNT_W        (4),
        .EDGE_MODE       (2),
        .BLINK_DIV_W     (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_raw       (in_raw),
        .in_level     (in_level),
        .edge_capture (edge_capture),
        .edge_clear   (edge_clear),
        .irq_mask     (irq_mask),
        .irq          (irq),
        .led_value    (led_value),
        .led_blink_en (led_blink_en),
        .led_out      (led_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step n cycles, checking in_level against a fixed value each cycle.
    task automatic step_hold(input string tag, input int n, input logic [1:0] lvl);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, 32'(in_level), 32'(lvl));
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        in_raw       = 2'b11;
        edge_clear   = 2'b00;
        irq_mask     = 2'b00;
        led_value    = 4'b0000;
        led_blink_en = 4'b0000;

        // Reset values
        repeat (3) step();
        check("rst_level", 32'(in_level), 32'h0);
        check("rst_cap",   32'(edge_capture), 32'h0);
        check("rst_irq",   32'(irq), 32'h0);
        check("rst_led",   32'(led_out), 32'hf);
        reset_n = 1'b1;
        repeat (20) step();
        check("idle_level", 32'(in_level), 32'h0);
        check("idle_cap",   32'(edge_capture), 32'h0);
        check("idle_irq",   32'(irq), 32'h0);
        check("idle_led",   32'(led_out), 32'hf);

        // Clean press on channel 0: accepted on the 10th edge
        in_raw[0] = 1'b0;
        step_hold("press_wait", 9, 2'b00);
        step();
        check("press_level", 32'(in_level), 32'h1);
        check("press_cap",   32'(edge_capture), 32'h1);
        irq_mask = 2'b01;
        #1;
        check("irq_masked_in", 32'(irq), 32'h1);
        irq_mask = 2'b00;
        #1;
        check("irq_masked_out", 32'(irq), 32'h0);
        irq_mask = 2'b10;
        #1;
        check("irq_other_mask", 32'(irq), 32'h0);
        irq_mask = 2'b00;

        // Clear race: release ch0, clear coincides with the release event
        in_raw[0] = 1'b1;
        step_hold("release_wait", 9, 2'b01);
        edge_clear = 2'b01;
        step();
        check("race_level", 32'(in_level), 32'h0);
        check("race_cap",   32'(edge_capture), 32'h1);
        step();
        check("clear_cap", 32'(edge_capture), 32'h0);
        edge_clear = 2'b00;

        // Bounce rejection on channel 1
        in_raw[1] = 1'b0;
        step_hold("bounce_a", 5, 2'b00);
        in_raw[1] = 1'b1;
        step_hold("bounce_b", 2, 2'b00);
        in_raw[1] = 1'b0;
        step_hold("bounce_c", 7, 2'b00);
        in_raw[1] = 1'b1;
        step_hold("bounce_d", 12, 2'b00);
        check("bounce_cap", 32'(edge_capture), 32'h0);

        // Stable press on channel 1 is accepted
        in_raw[1] = 1'b0;
        step_hold("ch1_wait", 9, 2'b00);
        step();
        check("ch1_level", 32'(in_level), 32'h2);
        check("ch1_cap",   32'(edge_capture), 32'h2);
        irq_mask = 2'b11;
        #1;
        check("ch1_irq", 32'(irq), 32'h1);

        // Release ch1: flag stays set (sticky), then clear it
        in_raw[1] = 1'b1;
        step_hold("ch1_rel_wait", 9, 2'b10);
        step_hold("ch1_rel", 3, 2'b00);
        check("ch1_sticky", 32'(edge_capture), 32'h2);
        edge_clear = 2'b10;
        step();
        edge_clear = 2'b00;
        check("ch1_clear", 32'(edge_capture), 32'h0);
        check("ch1_irq_off", 32'(irq), 32'h0);

        // LED blink
        led_value    = 4'b0101;
        led_blink_en = 4'b0100;
        repeat (2) step();
        for (int i = 0; i < 40; i++) begin
            step();
            samp[i] = led_out[2];
            check("led_static", 32'({led_out[3], led_out[1], led_out[0]}), 32'h6);
        end
        t0 = -1;
        for (int i = 1; i <= 17; i++) begin
            if (t0 < 0 && samp[i] != samp[i-1]) t0 = i;
        end
        check("blink_toggles", 32'(t0 >= 0), 32'h1);
        if (t0 >= 0) begin
            for (int j = 1; j < 20; j++) begin
                check("blink_phase", 32'(samp[t0+j]), 32'(samp[t0] ^ ((j / 8) % 2 == 1)));
            end
        end
        led_value    = 4'b0000;
        led_blink_en = 4'b0000;

        // Reset in the middle of a debounce
        in_raw[0] = 1'b0;
        step_hold("mid_wait", 5, 2'b00);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check("mid_rst_level", 32'(in_level), 32'h0);
        check("mid_rst_cap",   32'(edge_capture), 32'h0);
        for (int i = 0; i < 9; i++) begin
            step();
            check("mid_rst_hold_level", 32'(in_level), 32'h0);
            check("mid_rst_hold_cap",   32'(edge_capture), 32'h0);
        end
        step();
        check("mid_rst_level_up", 32'(in_level), 32'h1);
        check("mid_rst_cap_up",   32'(edge_capture), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
